uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares the single UART transmitter inside top_uart between two byte sources:
//   req0 = loopback/echo path, req1 = button-triggered message sender.
//   Round-robin arbitration at packet granularity. A packet is a byte run ending
//   with last=1, and the grant stays locked for the whole packet.
//   A watchdog releases the transmitter if it never reports done or if a locked
//   requester stalls. Sits between the byte sources and the UART TX core, on clk100MHz.
// PARAMETERS
//   DATA_W       8      byte width of request and tx data
//   TIMEOUT_CYC  20000  watchdog limit in cycles (> one 115200-baud frame at 100 MHz)
// PORTS
//   clk          in   1       system clock (100 MHz domain)
//   rst          in   1       synchronous, active-high reset
//   req0_valid   in   1       requester 0 has a byte; held with data/last until accepted
//   req0_data    in   DATA_W  requester 0 byte
//   req0_last    in   1       byte ends requester 0's packet
//   req0_ready   out  1       handshake: byte taken when valid&&ready
//   req1_valid   in   1       as req0
//   req1_data    in   DATA_W  as req0
//   req1_last    in   1       as req0
//   req1_ready   out  1       as req0
//   tx_start     out  1       one-cycle pulse: transmitter loads tx_data
//   tx_data      out  DATA_W  byte to transmit; registered, stable from tx_start to tx_done
//   tx_done      in   1       one-cycle pulse from the transmitter after the stop bit
//   grant        out  2       one-hot current owner; 00 = idle
//   timeout_err  out  1       one-cycle pulse when the watchdog fires
// BEHAVIOUR
// - Clock and reset: one clock (clk). rst is synchronous and active-high.
// - Reset state: state=IDLE, ptr=0 (req0 preferred). All outputs 0, tx_data=0, watchdog count=0.
//   Mid-operation reset returns to IDLE the next cycle. The UART core is not aborted by this block.
// - States:
//   IDLE    If no valid, stay. Else choose the owner: if only one valid, that one;
//           if both valid, the one ptr points to. Set grant, go to ACCEPT.
//   ACCEPT  readyX=1 only for the owner, registered (high in every ACCEPT cycle).
//           On owner valid&&ready: capture data into tx_data and last into last_q,
//           go to START.
//   START   tx_start=1 for exactly one cycle. Go to WAIT.
//   WAIT    On tx_done:
//             last_q=0 -> go to ACCEPT with the same owner (packet lock).
//             last_q=1 -> grant=00, ptr=other requester, go to IDLE.
// - Latency: valid rises in IDLE at cycle T; ready is high at T+1; tx_start is high at T+2.
//   Back-to-back within a packet: ready is high the cycle after tx_done.
// - Watchdog:
//   - Counter width $clog2(TIMEOUT_CYC+1); cleared on every state entry.
//   - Counts in WAIT, and in ACCEPT while the owner's valid=0.
//   - When count reaches TIMEOUT_CYC-1: timeout_err=1 for one cycle, grant=00,
//     ptr=other requester, go to IDLE. A partial packet is abandoned.
// - Boundary rules:
//   - tx_done outside WAIT is ignored.
//   - tx_done in the same cycle as watchdog expiry: done wins, no timeout_err.
//   - The non-owner's ready is always 0, and its valid never affects a locked packet.
//   - A requester valid while another owns the grant simply waits; no pulse is lost.
//   - ptr changes only at packet end or timeout, never on single-requester traffic.
// TESTING
//   1 After reset, req0 sends 0xA5 with last=1 at T -> req0_ready=1 at T+1;
//     tx_start=1 at T+2 with tx_data=0xA5; grant=01 until tx_done, then 00.
//   2 Both valid from IDLE: req0 sends 0x48(last=0), 0x49(last=1); req1 sends 0x21
//     -> tx order 48,49,21; grant stays 01 across both req0 bytes; req1_ready=0 meanwhile.
//   3 Both requesters continuously valid with single-byte packets -> grant alternates
//     01,10,01,10; no requester is served twice in a row.
//   4 TIMEOUT_CYC=16 and tx_done never pulses -> timeout_err pulse 16 cycles after WAIT
//     entry; grant=00; the pending req1 is served next.
//   5 req0 sends last=0 then drops valid; req1 is valid -> req1_ready stays 0 until the
//     timeout fires; then req1 is accepted and transmitted.
//   6 rst asserted in WAIT -> next cycle all outputs 0; a following stray tx_done
//     produces no tx_start and no state change.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that lets two byte sources share one UART
// transmitter. A watchdog recovers from a silent transmitter or a stalled owner.
module uart_tx_arbiter #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_done,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, ACCEPT, START, WAIT} state_t;

  state_t            state, state_n;
  logic              ptr, ptr_n;
  logic              last_q, last_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [1:0]        grant_n;
  logic [DATA_W-1:0] data_n;
  logic              r0_n, r1_n, start_n, terr_n;

  logic              owner1, owner_valid, pick1, expire;
  logic [DATA_W-1:0] owner_data;
  logic              owner_last;

  assign owner1      = grant[1];
  assign owner_valid = owner1 ? req1_valid : req0_valid;
  assign owner_data  = owner1 ? req1_data  : req0_data;
  assign owner_last  = owner1 ? req1_last  : req0_last;
  assign pick1       = req1_valid && (!req0_valid || ptr);
  assign expire      = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    last_n  = last_q;
    cnt_n   = cnt;
    grant_n = grant;
    data_n  = tx_data;
    r0_n    = req0_ready;
    r1_n    = req1_ready;
    start_n = 1'b0;
    terr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_n = pick1 ? 2'b10 : 2'b01;
          r0_n    = !pick1;
          r1_n    = pick1;
          cnt_n   = '0;
          state_n = ACCEPT;
        end
      end
      ACCEPT: begin
        if (owner_valid) begin
          data_n  = owner_data;
          last_n  = owner_last;
          r0_n    = 1'b0;
          r1_n    = 1'b0;
          start_n = 1'b1;
          cnt_n   = '0;
          state_n = START;
        end else if (expire) begin
          terr_n  = 1'b1;
          grant_n = '0;
          r0_n    = 1'b0;
          r1_n    = 1'b0;
          ptr_n   = !owner1;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      START: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        // tx_done takes priority over a watchdog expiry in the same cycle
        if (tx_done) begin
          cnt_n = '0;
          if (last_q) begin
            grant_n = '0;
            ptr_n   = !owner1;
            state_n = IDLE;
          end else begin
            r0_n    = !owner1;
            r1_n    = owner1;
            state_n = ACCEPT;
          end
        end else if (expire) begin
          terr_n  = 1'b1;
          grant_n = '0;
          ptr_n   = !owner1;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      last_q      <= 1'b0;
      cnt         <= '0;
      grant       <= '0;
      tx_data     <= '0;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      last_q      <= last_n;
      cnt         <= cnt_n;
      grant       <= grant_n;
      tx_data     <= data_n;
      req0_ready  <= r0_n;
      req1_ready  <= r1_n;
      tx_start    <= start_n;
      timeout_err <= terr_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle tables for the basic transfers,
// hand-written sequences for rotation, watchdog and reset corner cases.
module tb_uart_tx_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic       tx_start, tx_done, timeout_err;
  logic [7:0] tx_data;
  logic [1:0] grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DATA_W(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .grant(grant), .timeout_err(timeout_err)
  );

  typedef struct {
    logic       v0; logic [7:0] d0; logic l0;
    logic       v1; logic [7:0] d1; logic l1;
    logic       done;
    logic       r0, r1, st;
    logic [7:0] data;
    logic [1:0] gr;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(logic v0, logic [7:0] d0, logic l0, logic v1, logic [7:0] d1,
                              logic l1, logic done, logic r0, logic r1, logic st,
                              logic [7:0] data, logic [1:0] gr);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.l0 = l0; v.v1 = v1; v.d1 = d1; v.l1 = l1; v.done = done;
    v.r0 = r0; v.r1 = r1; v.st = st; v.data = data; v.gr = gr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_data = '0; req0_last = 0;
    req1_valid = 0; req1_data = '0; req1_last = 0;
    tx_done = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx_start) begin
        ok = 1;
        break;
      end
    end
    chk("tx_start_seen", 32'(ok), 32'd1);
  endtask

  task automatic pulse_done();
    tx_done = 1;
    tick();
    tx_done = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_ready"}, 32'({req0_ready, req1_ready}), 32'd0);
    chk({tag, "_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_terr"}, 32'(timeout_err), 32'd0);
  endtask

  task automatic run_vec(input int i);
    req0_valid = vt[i].v0; req0_data = vt[i].d0; req0_last = vt[i].l0;
    req1_valid = vt[i].v1; req1_data = vt[i].d1; req1_last = vt[i].l1;
    tx_done    = vt[i].done;
    tick();
    chk($sformatf("vec%0d_r0", i), 32'(req0_ready), 32'(vt[i].r0));
    chk($sformatf("vec%0d_r1", i), 32'(req1_ready), 32'(vt[i].r1));
    chk($sformatf("vec%0d_start", i), 32'(tx_start), 32'(vt[i].st));
    chk($sformatf("vec%0d_data", i), 32'(tx_data), 32'(vt[i].data));
    chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vt[i].gr));
    chk($sformatf("vec%0d_terr", i), 32'(timeout_err), 32'd0);
  endtask

  initial begin
    bit ok;
    int n;
    logic [1:0] exp_gr;
    logic [7:0] exp_d;

    //              v0 d0    l0 v1 d1    l1 dn  r0 r1 st data   gr
    // single byte from req0
    vt[0]  = mk(1, 8'hA5, 1, 0, 8'h00, 0, 0,  1, 0, 0, 8'h00, 2'b01);
    vt[1]  = mk(1, 8'hA5, 1, 0, 8'h00, 0, 0,  0, 0, 1, 8'hA5, 2'b01);
    vt[2]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 0, 0, 8'hA5, 2'b01);
    vt[3]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 0, 0, 8'hA5, 2'b01);
    vt[4]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'hA5, 2'b00);
    vt[5]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 0, 0, 8'hA5, 2'b00);
    // both valid: req0 two-byte packet locks out req1
    vt[6]  = mk(1, 8'h48, 0, 1, 8'h21, 1, 0,  1, 0, 0, 8'h00, 2'b01);
    vt[7]  = mk(1, 8'h48, 0, 1, 8'h21, 1, 0,  0, 0, 1, 8'h48, 2'b01);
    vt[8]  = mk(1, 8'h49, 1, 1, 8'h21, 1, 0,  0, 0, 0, 8'h48, 2'b01);
    vt[9]  = mk(1, 8'h49, 1, 1, 8'h21, 1, 1,  1, 0, 0, 8'h48, 2'b01);
    vt[10] = mk(1, 8'h49, 1, 1, 8'h21, 1, 0,  0, 0, 1, 8'h49, 2'b01);
    vt[11] = mk(0, 8'h00, 0, 1, 8'h21, 1, 0,  0, 0, 0, 8'h49, 2'b01);
    vt[12] = mk(0, 8'h00, 0, 1, 8'h21, 1, 1,  0, 0, 0, 8'h49, 2'b00);
    vt[13] = mk(0, 8'h00, 0, 1, 8'h21, 1, 0,  0, 1, 0, 8'h49, 2'b10);
    vt[14] = mk(0, 8'h00, 0, 1, 8'h21, 1, 0,  0, 0, 1, 8'h21, 2'b10);
    vt[15] = mk(0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 0, 0, 8'h21, 2'b10);
    vt[16] = mk(0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h21, 2'b00);

    rst = 1;
    idle_inputs();
    tick();
    tick();
    check_outputs_zero("reset");
    chk("reset_data", 32'(tx_data), 32'd0);
    rst = 0;

    // stray tx_done in IDLE is ignored
    pulse_done();
    tick();
    check_outputs_zero("stray_idle");

    for (int i = 0; i < 6; i++) run_vec(i);
    do_reset();
    for (int i = 6; i < 17; i++) run_vec(i);

    // continuous single-byte packets from both sides alternate
    do_reset();
    req0_valid = 1; req0_data = 8'h10; req0_last = 1;
    req1_valid = 1; req1_data = 8'h20; req1_last = 1;
    for (int k = 0; k < 4; k++) begin
      exp_gr = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_d  = (k % 2 == 0) ? 8'h10 : 8'h20;
      wait_start(ok);
      chk($sformatf("rr%0d_grant", k), 32'(grant), 32'(exp_gr));
      chk($sformatf("rr%0d_data", k), 32'(tx_data), 32'(exp_d));
      tick();
      pulse_done();
    end

    // silent transmitter: watchdog fires 16 cycles after WAIT entry
    do_reset();
    req0_valid = 1; req0_data = 8'h55; req0_last = 1;
    req1_valid = 1; req1_data = 8'h66; req1_last = 1;
    wait_start(ok);
    chk("wd_first_grant", 32'(grant), 32'b01);
    req0_valid = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (timeout_err) break;
    end
    chk("wd_wait_latency", 32'(n), 32'd17);
    chk("wd_grant_cleared", 32'(grant), 32'd0);
    tick();
    chk("wd_terr_one_cycle", 32'(timeout_err), 32'd0);
    wait_start(ok);
    chk("wd_next_grant", 32'(grant), 32'b10);
    chk("wd_next_data", 32'(tx_data), 32'h66);
    req1_valid = 0;
    // tx_done in the expiry cycle wins over the watchdog
    for (int i = 0; i < 16; i++) tick();
    pulse_done();
    chk("done_wins_terr", 32'(timeout_err), 32'd0);
    chk("done_wins_grant", 32'(grant), 32'd0);
    tick();
    chk("done_wins_terr_late", 32'(timeout_err), 32'd0);

    // owner stalls mid-packet; req1 is locked out until the watchdog fires
    do_reset();
    req0_valid = 1; req0_data = 8'h30; req0_last = 0;
    req1_valid = 1; req1_data = 8'h77; req1_last = 1;
    wait_start(ok);
    chk("stall_grant", 32'(grant), 32'b01);
    req0_valid = 0;
    tick();
    tick();
    pulse_done();
    chk("stall_reaccept", 32'(req0_ready), 32'd1);
    n = 0;
    ok = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (timeout_err) break;
      if (req1_ready) ok = 0;
    end
    chk("stall_r1_blocked", 32'(ok), 32'd1);
    chk("stall_latency", 32'(n), 32'd16);
    chk("stall_grant_cleared", 32'(grant), 32'd0);
    wait_start(ok);
    chk("stall_req1_grant", 32'(grant), 32'b10);
    chk("stall_req1_data", 32'(tx_data), 32'h77);
    req1_valid = 0;
    tick();
    pulse_done();

    // reset while in WAIT, then a stray tx_done
    do_reset();
    req0_valid = 1; req0_data = 8'h99; req0_last = 1;
    wait_start(ok);
    req0_valid = 0;
    tick();
    chk("rstwait_grant_before", 32'(grant), 32'b01);
    rst = 1;
    tick();
    check_outputs_zero("rstwait");
    chk("rstwait_data", 32'(tx_data), 32'd0);
    rst = 0;
    pulse_done();
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      if (tx_start || grant != 2'b00 || timeout_err) ok = 0;
      tick();
    end
    chk("rstwait_stray_done_quiet", 32'(ok), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
